tagged_dispatch_fifos: RTL and testbench

//  Distribution counterpart of the arbitrated, encoded multi-FIFO path: one producer stream carries an

---
 rtl/tagged_dispatch_fifos.sv | 118 +++++++++++
 tb/tb_tagged_dispatch_fifos.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tagged_dispatch_fifos.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tagged_dispatch_fifos                                           |
// | Purpose  : Decodes a destination tag, registers the beat in a one-entry    |
// |            routing stage and writes it into one of NUM_FIFOS FWFT FIFOs.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tagged_dispatch_fifos #(
  parameter int NUM_FIFOS = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [TAGWIDTH-1:0]        push_tag,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       in_ready,
  input  logic [NUM_FIFOS-1:0]       pop,
  output logic [NUM_FIFOS*WIDTH-1:0] flat_data_out,
  output logic [NUM_FIFOS-1:0]       empty,
  output logic [NUM_FIFOS-1:0]       full,
  output logic                       tag_err
);

  localparam int                c_PTR_W    = $clog2(DEPTH);
  localparam int                c_CNT_W    = c_PTR_W + 1;
  localparam logic [TAGWIDTH:0] c_NUM_TAGS = (TAGWIDTH + 1)'(NUM_FIFOS);

  logic                 r_stage_vld;
  logic [TAGWIDTH-1:0]  r_stage_tag;
  logic [WIDTH-1:0]     r_stage_data;
  logic                 r_tag_err;

  logic [NUM_FIFOS-1:0] w_sel;
  logic [NUM_FIFOS-1:0] w_wr;
  logic                 w_drain;
  logic                 w_accept;
  logic                 w_bad_tag;

  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_sel
    assign w_sel[i] = (r_stage_tag == TAGWIDTH'(i));
  end

  // An out-of-range tag selects no FIFO, so it is never blocked and drains at once.
  assign w_drain   = r_stage_vld & ~|(w_sel & full & ~pop);
  assign in_ready  = ~r_stage_vld | w_drain;
  assign w_accept  = push & in_ready;
  assign w_bad_tag = ({1'b0, push_tag} >= c_NUM_TAGS);
  assign w_wr      = w_sel & {NUM_FIFOS{w_drain}};
  assign tag_err   = r_tag_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage_vld  <= 1'b0;
      r_stage_tag  <= '0;
      r_stage_data <= '0;
      r_tag_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_stage_vld  <= 1'b1;
        r_stage_tag  <= push_tag;
        r_stage_data <= data_in;
      end else if (w_drain) begin
        r_stage_vld  <= 1'b0;
      end
      if (w_accept && w_bad_tag) begin
        r_tag_err <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_fifo
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_empty;
    logic               w_rd;

    assign w_empty = (r_count == '0);
    // A pop on an empty FIFO is dropped even when a write lands the same cycle.
    assign w_rd    = pop[i] & ~w_empty;

    always_ff @(posedge clk) begin
      if (w_wr[i]) begin
        r_mem[r_wr_ptr] <= r_stage_data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr[i]) begin
          r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        end
        if (w_rd) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        end
        case ({w_wr[i], w_rd})
          2'b10:   r_count <= r_count + c_CNT_W'(1);
          2'b01:   r_count <= r_count - c_CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end

    assign empty[i] = w_empty;
    assign full[i]  = (r_count == c_CNT_W'(DEPTH));
    assign flat_data_out[i*WIDTH +: WIDTH] = w_empty ? '0 : r_mem[r_rd_ptr];
  end

endmodule
`default_nettype wire

// File: tb/tb_tagged_dispatch_fifos.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tagged_dispatch_fifos                                        |
// | Purpose  : Scoreboard bench for tagged_dispatch_fifos (4-way and 3-way).   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_tagged_dispatch_fifos;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic [1:0]  push_tag;
  logic [7:0]  data_in;
  logic        in_ready;
  logic [3:0]  pop;
  logic [31:0] flat_data_out;
  logic [3:0]  empty;
  logic [3:0]  full;
  logic        tag_err;

  logic        push1;
  logic [1:0]  push_tag1;
  logic [7:0]  data_in1;
  logic        in_ready1;
  logic [2:0]  pop1;
  logic [23:0] flat_data_out1;
  logic [2:0]  empty1;
  logic [2:0]  full1;
  logic        tag_err1;

  int checks = 0;
  int errors = 0;

  // Reference model of the 4-way instance: staged beat plus one queue per FIFO.
  logic       m_vld;
  logic [1:0] m_tag;
  logic [7:0] m_data;
  logic [7:0] mq [4][$];

  tagged_dispatch_fifos dut (
    .clk(clk), .rst(rst), .push(push), .push_tag(push_tag), .data_in(data_in),
    .in_ready(in_ready), .pop(pop), .flat_data_out(flat_data_out),
    .empty(empty), .full(full), .tag_err(tag_err)
  );

  tagged_dispatch_fifos #(.NUM_FIFOS(3), .WIDTH(8), .DEPTH(8), .TAGWIDTH(2)) dut3 (
    .clk(clk), .rst(rst), .push(push1), .push_tag(push_tag1), .data_in(data_in1),
    .in_ready(in_ready1), .pop(pop1), .flat_data_out(flat_data_out1),
    .empty(empty1), .full(full1), .tag_err(tag_err1)
  );

  always #5 clk = ~clk;

  function automatic logic model_ready();
    logic blocked;
    blocked = m_vld && (mq[m_tag].size() == 8) && !pop[m_tag];
    return !m_vld || !blocked;
  endfunction

  // Clock one edge from current inputs, advance the model, return idle at negedge.
  task automatic tick();
    logic drain;
    logic acc;
    drain = m_vld && !((mq[m_tag].size() == 8) && !pop[m_tag]);
    acc   = push && model_ready();
    @(posedge clk);
    if (rst) begin
      m_vld = 1'b0;
      for (int i = 0; i < 4; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < 4; i++)
        if (pop[i] && mq[i].size() > 0) void'(mq[i].pop_front());
      if (drain) mq[m_tag].push_back(m_data);
      if (acc) begin
        m_vld = 1'b1; m_tag = push_tag; m_data = data_in;
      end else if (drain) begin
        m_vld = 1'b0;
      end
    end
    @(negedge clk);
    push = 1'b0; pop = '0; push1 = 1'b0; pop1 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (empty !== 4'hF) begin errors++; $display("FAIL reset_empty got %b expected 1111", empty); end
    checks++; if (full !== 4'h0) begin errors++; $display("FAIL reset_full got %b expected 0000", full); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
    checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL reset_tag_err got %b expected 0", tag_err); end
    checks++; if (flat_data_out !== 32'h0) begin errors++; $display("FAIL reset_data got %h expected 0", flat_data_out); end
  endtask

  task automatic test_single();
    do_reset();
    push = 1'b1; push_tag = 2'd2; data_in = 8'hA5;
    tick();
    #1;
    checks++; if (empty !== 4'hF) begin errors++; $display("FAIL single_staged_empty got %b expected 1111", empty); end
    tick();
    #1;
    checks++; if (empty !== 4'b1011) begin errors++; $display("FAIL single_empty got %b expected 1011", empty); end
    checks++; if (flat_data_out[23:16] !== 8'hA5) begin errors++; $display("FAIL single_head got %h expected a5", flat_data_out[23:16]); end
  endtask

  task automatic test_full_backpressure();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      push = 1'b1; push_tag = 2'd1; data_in = 8'(8'h10 + k);
      tick();
    end
    #1;
    checks++; if (full[1] !== 1'b1) begin errors++; $display("FAIL bp_full got %b expected 1", full[1]); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_idle got %b expected 0", in_ready); end
    push = 1'b1; push_tag = 2'd0; data_in = 8'h77;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_push got %b expected 0", in_ready); end
    tick();
    #1;
    checks++; if (empty[0] !== 1'b1) begin errors++; $display("FAIL bp_fifo0_empty got %b expected 1", empty[0]); end
    checks++; if (flat_data_out[15:8] !== 8'h10) begin errors++; $display("FAIL bp_head_before got %h expected 10", flat_data_out[15:8]); end
    pop[1] = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_pop got %b expected 1", in_ready); end
    tick();
    #1;
    checks++; if (flat_data_out[15:8] !== 8'h11) begin errors++; $display("FAIL bp_head_after got %h expected 11", flat_data_out[15:8]); end
    checks++; if (full[1] !== 1'b1) begin errors++; $display("FAIL bp_full_after got %b expected 1", full[1]); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b expected 1", in_ready); end
    for (int k = 1; k < 9; k++) begin
      #1;
      checks++; if (flat_data_out[15:8] !== 8'(8'h10 + k)) begin errors++; $display("FAIL bp_drain[%0d] got %h expected %h", k, flat_data_out[15:8], 8'(8'h10 + k)); end
      pop[1] = 1'b1;
      tick();
    end
    #1;
    checks++; if (empty[1] !== 1'b1) begin errors++; $display("FAIL bp_drained_empty got %b expected 1", empty[1]); end
  endtask

  task automatic test_random();
    logic [7:0] exp_head;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      push     = ($urandom_range(0, 9) < 7);
      push_tag = 2'($urandom_range(0, 3));
      data_in  = 8'($urandom);
      for (int i = 0; i < 4; i++) pop[i] = (mq[i].size() > 0) && ($urandom_range(0, 9) < 3);
      #1;
      checks++; if (in_ready !== model_ready()) begin errors++; $display("FAIL rnd_ready cycle %0d got %b expected %b", c, in_ready, model_ready()); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (empty[i] !== (mq[i].size() == 0)) begin errors++; $display("FAIL rnd_empty[%0d] cycle %0d got %b expected %b", i, c, empty[i], mq[i].size() == 0); end
        checks++; if (full[i] !== (mq[i].size() == 8)) begin errors++; $display("FAIL rnd_full[%0d] cycle %0d got %b expected %b", i, c, full[i], mq[i].size() == 8); end
        if (mq[i].size() > 0) begin
          exp_head = mq[i][0];
          checks++; if (flat_data_out[i*8 +: 8] !== exp_head) begin errors++; $display("FAIL rnd_head[%0d] cycle %0d got %h expected %h", i, c, flat_data_out[i*8 +: 8], exp_head); end
        end
      end
      tick();
    end
  endtask

  task automatic test_bad_tag();
    do_reset();
    #1;
    checks++; if (tag_err1 !== 1'b0) begin errors++; $display("FAIL bad_tag_initial got %b expected 0", tag_err1); end
    push1 = 1'b1; push_tag1 = 2'd3; data_in1 = 8'h5A;
    tick();
    tick();
    tick();
    #1;
    checks++; if (tag_err1 !== 1'b1) begin errors++; $display("FAIL bad_tag_set got %b expected 1", tag_err1); end
    checks++; if (empty1 !== 3'b111) begin errors++; $display("FAIL bad_tag_nowrite got %b expected 111", empty1); end
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL bad_tag_ready got %b expected 1", in_ready1); end
    push1 = 1'b1; push_tag1 = 2'd0; data_in1 = 8'h3C;
    tick();
    tick();
    #1;
    checks++; if (empty1 !== 3'b110) begin errors++; $display("FAIL bad_tag_good_write got %b expected 110", empty1); end
    checks++; if (flat_data_out1[7:0] !== 8'h3C) begin errors++; $display("FAIL bad_tag_good_head got %h expected 3c", flat_data_out1[7:0]); end
    checks++; if (tag_err1 !== 1'b1) begin errors++; $display("FAIL bad_tag_sticky got %b expected 1", tag_err1); end
    do_reset();
    #1;
    checks++; if (tag_err1 !== 1'b0) begin errors++; $display("FAIL bad_tag_cleared got %b expected 0", tag_err1); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      push = 1'b1; push_tag = 2'd0; data_in = 8'(8'hC0 + k);
      tick();
    end
    #1;
    checks++; if (empty[0] !== 1'b0) begin errors++; $display("FAIL mid_filled got %b expected 0", empty[0]); end
    do_reset();
    #1;
    checks++; if (empty !== 4'hF) begin errors++; $display("FAIL mid_empty got %b expected 1111", empty); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b expected 1", in_ready); end
    checks++; if (full !== 4'h0) begin errors++; $display("FAIL mid_full got %b expected 0000", full); end
    tick();
    tick();
    #1;
    checks++; if (empty !== 4'hF) begin errors++; $display("FAIL mid_stale_write got %b expected 1111", empty); end
  endtask

  initial begin
    rst = 1'b0; push = 1'b0; push_tag = '0; data_in = '0; pop = '0;
    push1 = 1'b0; push_tag1 = '0; data_in1 = '0; pop1 = '0;
    m_vld = 1'b0; m_tag = '0; m_data = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_full_backpressure();
    test_random();
    test_bad_tag();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
